// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice resolved per
// stage, carry registered between stages, global-stall valid/ready handshake.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = WIDTH / CHUNK;

  // Rank 0 is the capture register; rank k+1 holds the result of stage k.
  logic [STAGES:0]   v;
  logic [STAGES:0]   c;
  logic [WIDTH-1:0]  acc [0:STAGES];
  logic [WIDTH-1:0]  opb [0:STAGES-1];
  logic [STAGES-1:0] am;
  logic [STAGES-1:0] bm;
  logic              ovf_q;
  logic [CHUNK:0]    ss [0:STAGES-1];
  logic [WIDTH-1:0]  b_eff;
  logic              adv;

  // Handshake: input accepted on in_valid && in_ready, result consumed on
  // out_valid && out_ready; the whole pipeline stalls while out_valid && !out_ready.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign b_eff     = sub ? ~b : b;
  assign out_valid = v[STAGES];
  assign sum       = acc[STAGES];
  assign cout      = c[STAGES];
  assign overflow  = ovf_q;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ss[k] = {1'b0, acc[k][k*CHUNK +: CHUNK]} + {1'b0, opb[k][k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, c[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= '0;
      c     <= '0;
      am    <= '0;
      bm    <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k <= STAGES; k++) acc[k] <= '0;
      for (int k = 0; k < STAGES; k++) opb[k] <= '0;
    end else if (adv) begin
      v[0]   <= in_valid;
      acc[0] <= a;
      opb[0] <= b_eff;
      c[0]   <= sub ? ~cin : cin;
      am[0]  <= a[WIDTH-1];
      bm[0]  <= b_eff[WIDTH-1];
      // Resolved slices overwrite the operand-a bits they replace.
      for (int k = 0; k < STAGES; k++) begin
        v[k+1]                      <= v[k];
        c[k+1]                      <= ss[k][CHUNK];
        acc[k+1]                    <= acc[k];
        acc[k+1][k*CHUNK +: CHUNK]  <= ss[k][CHUNK-1:0];
      end
      for (int k = 1; k < STAGES; k++) begin
        opb[k] <= opb[k-1];
        am[k]  <= am[k-1];
        bm[k]  <= bm[k-1];
      end
      ovf_q <= (am[STAGES-1] == bm[STAGES-1]) &&
               (ss[STAGES-1][CHUNK-1] != am[STAGES-1]);
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: reset, latency, hand-computed vectors, random
// stream, backpressure and mid-flight reset, with an in-order scoreboard.
module tb_addsub_pipe;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int XW = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, in_valid, in_ready, cout, overflow, out_valid, out_ready;

  int vectors     = 0;
  int miscompares = 0;
  int n_out       = 0;
  logic [XW-1:0] exp_q[$];

  addsub_pipe #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
    .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model from the arithmetic definition: {overflow, cout, sum}
  function automatic logic [XW-1:0] model(input logic [W-1:0] fa, fb, input logic fc, fs);
    logic [W-1:0] be;
    logic [W:0]   t;
    be = fs ? ~fb : fb;
    t  = {1'b0, fa} + {1'b0, be} + {{W{1'b0}}, (fs ? ~fc : fc)};
    return {(fa[W-1] == be[W-1]) && (t[W-1] != fa[W-1]), t};
  endfunction

  task automatic chk(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
    logic rb;
    int   g;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    g = 0;
    do begin
      rb = in_ready;
      step();
      g++;
    end while (!rb && g < 50);
    chk("send_accept", XW'(rb), XW'(1'b1));
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, XW'(out_valid), XW'(1'b1));
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic ts, input logic [XW-1:0] exp);
    send(ta, tb_, tc, ts);
    in_valid = 1'b0;
    wait_valid(tag);
    chk(tag, {overflow, cout, sum}, exp);
    step();
  endtask

  // scoreboard: in-order expected queue
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL unexpected_result: got %h expected none", {overflow, cout, sum});
        end else begin
          chk("stream_result", {overflow, cout, sum}, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  initial begin
    logic [XW-1:0] held, first_exp;
    logic [W-1:0]  ra, rb;
    logic          rc, rs;
    int            n0;

    rst = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_out_valid", XW'(out_valid), XW'(1'b0));
    chk("reset_in_ready", XW'(in_ready), XW'(1'b1));
    chk("reset_data", {overflow, cout, sum}, '0);

    // carry ripple through every slice, with exact latency
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    chk("lat_in_ready", XW'(in_ready), XW'(1'b1));
    step();
    in_valid = 1'b0;
    chk("lat_edge0", XW'(out_valid), XW'(1'b0));
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("lat_early", XW'(out_valid), XW'(1'b0));
    end
    step();
    chk("lat_edge4", XW'(out_valid), XW'(1'b1));
    chk("ripple", {overflow, cout, sum}, {1'b0, 1'b1, 32'h0000_0000});
    step();

    // hand-computed subtract and overflow vectors
    run_one("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    run_one("sub_bin",    32'd7, 32'd5, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0001});
    run_one("add_ovf",    32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
    run_one("sub_ovf",    32'h8000_0000, 32'd1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    run_one("add_cin",    32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0000_0100});

    // back-to-back random stream
    n0 = n_out;
    for (int i = 0; i < 100; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    repeat (8) step();
    chk("stream_count", XW'(n_out - n0), XW'(100));
    chk("stream_drained", XW'(exp_q.size()), XW'(0));

    // backpressure: fill while blocked, hold 3 cycles, release
    out_ready = 1'b0;
    n0 = n_out;
    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    first_exp = model(ra, rb, rc, rs);
    send(ra, rb, rc, rs);
    for (int i = 1; i < 5; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    chk("bp_out_valid", XW'(out_valid), XW'(1'b1));
    chk("bp_in_ready", XW'(in_ready), XW'(1'b0));
    chk("bp_head", {overflow, cout, sum}, first_exp);
    held = {overflow, cout, sum};
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", XW'(out_valid), XW'(1'b1));
      chk("bp_hold_ready", XW'(in_ready), XW'(1'b0));
      chk("bp_hold_data", {overflow, cout, sum}, held);
    end
    out_ready = 1'b1;
    repeat (8) step();
    chk("bp_count", XW'(n_out - n0), XW'(5));
    chk("bp_drained", XW'(exp_q.size()), XW'(0));

    // reset mid-flight, with an operation offered during the reset cycle
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b1);
    send(32'h5555_5555, 32'h6666_6666, 1'b0, 1'b0);
    a = 32'h7777_7777; b = 32'h0000_0001; in_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mrst_out_valid", XW'(out_valid), XW'(1'b0));
    chk("mrst_in_ready", XW'(in_ready), XW'(1'b1));
    chk("mrst_data", {overflow, cout, sum}, '0);
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mrst_no_result", XW'(out_valid), XW'(1'b0));
    end
    chk("mrst_count", XW'(n_out - n0), XW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
